vga_framebuffer: RTL and testbench
==================================

# vga_framebuffer

Double-buffered 4-bit indexed framebuffer that sits directly upstream of the VGA colour stage. It answers the colour stage's pixel read address with a palette index from the front buffer. It accepts renderer writes into the back buffer over a valid/ready handshake. On request, it swaps front and back during vertical blanking and optionally clears the new back buffer to a fill index.

## Interface

Parameters:
- H_RES, 800: visible pixels per line
- V_RES, 480: visible lines
- ADDR_W, 19: pixel address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES
- DATA_W, 4: palette index width
- CLEAR_ON_SWAP, 1: 1 = clear the new back buffer after each swap; 0 = skip the clear

Ports:
- pixel_clk  in  1  sole clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- rd_addr  in  ADDR_W  pixel address from the colour stage (sy*H_RES+sx)
- rd_data  out  DATA_W  front-buffer palette index, registered
- vblank  in  1  high while the timing generator is in vertical blanking
- wr_valid  in  1  renderer write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready; registered
- wr_addr  in  ADDR_W  back-buffer pixel address
- wr_data  in  DATA_W  palette index to write
- swap_req  in  1  single-cycle pulse: the back buffer is complete
- clear_color  in  DATA_W  fill index, sampled when swap_req is accepted
- front_sel  out  1  index of the buffer currently displayed
- busy  out  1  high in PENDING and CLEAR

## Operation

- Storage:
  - Two arrays buf0/buf1, each of N = H_RES*V_RES entries × DATA_W bits.
  - Each array is inferred as simple dual-port block RAM (one read port, one write port).
  - Contents are not reset.
- Read path:
  - rd_data <= (rd_addr < N) ? buf[front_sel][rd_addr] : 0.
  - Latency is 1 cycle.
- Write path:
  - Only the back buffer (!front_sel) is written.
  - Source is the renderer in DRAW and the clear counter in CLEAR.
  - An accepted write with wr_addr ≥ N completes the handshake and is discarded.
- FSM states and transitions:
  - DRAW: wr_ready=1. If swap_req, latch clear_color and go to PENDING. A write presented in the same cycle as swap_req is accepted.
  - PENDING: wr_ready=0. If vblank=1, toggle front_sel and go to CLEAR; if CLEAR_ON_SWAP=0, go to DRAW instead.
  - CLEAR:
    - wr_ready=0.
    - clr_addr runs 0..N-1, one write of the latched colour per cycle.
    - After the write at N-1, go to DRAW.
- swap_req is ignored in PENDING and CLEAR; there is no queuing.
- Arithmetic:
  - clr_addr is ADDR_W bits and compares against N-1 exactly; no wrap.
  - The rd_addr and wr_addr range checks are unsigned compares against N.

## Timing

- Reset values (any cycle with rst_n=0, taking effect at that edge):
  - State DRAW, front_sel=0, rd_data=0, wr_ready=0, busy=0, clr_addr=0.
  - wr_ready goes to 1 on the first edge with rst_n=1.
- Reset mid-operation: reset from PENDING or CLEAR returns to the reset state. A partially cleared buffer is left as-is.
- wr_ready and busy are registered from the next state, so both change on the same edge as the state.
- Swap accepted in cycle T:
  - State is PENDING from T+1; wr_ready=0 and busy=1 from T+1.
- Let P be the first PENDING cycle with vblank=1:
  - front_sel toggles at the end of P.
  - A read sampled in P returns old-front data; a read sampled in P+1 returns new-front data.
  - With vblank already 1 at T+1, P = T+1.
- Clear:
  - Writes occur in cycles P+1 .. P+N.
  - State is DRAW and wr_ready=1 from P+N+1; busy=0 from the same cycle.
  - With CLEAR_ON_SWAP=0, wr_ready=1 from P+1.
- vblank going low while PENDING: keep waiting; the swap happens only with vblank=1.
- Simultaneous events:
  - A write and swap_req in the same DRAW cycle: the write lands in the old back buffer before the swap.
  - A read and a write to the same address in one cycle never conflict, because they target different arrays.

## Test plan

- Reset: hold rst_n=0 for 3 cycles with wr_valid=1 and swap_req=1 -> rd_data=0, front_sel=0, busy=0, wr_ready=0; the cycle after release wr_ready=1 and no write has occurred.
- Write and swap:
  - Stimulus: write addr 5 = 0xA, pulse swap_req with vblank=1, then drive rd_addr=5 continuously.
  - Required: front_sel=1 at T+2. rd_data=0xA one cycle after a read sampled at or after T+2.
  - Required: a read sampled at T+1 returns buf0[5].
- Deferred swap with clear:
  - Stimulus: clear_color=0x3, swap_req at T with vblank=0; raise vblank at T+10.
  - Required: busy=1 and wr_ready=0 from T+1; front_sel toggles at the end of T+10.
  - Required: wr_ready=1 exactly at T+11+384000, and every entry of the new back buffer reads 0x3 after the next swap.
- Out-of-range access: rd_addr=384000 -> rd_data=0 next cycle; a write to wr_addr=384000 with data 0xF is handshaked and no in-range entry changes.
- Ignored swap: pulse swap_req during CLEAR -> no extra PENDING, front_sel toggles exactly once.
- Reset mid-clear: assert rst_n=0 at clear cycle 1000 -> state DRAW, front_sel=0, wr_ready=1 the cycle after release, busy=0.

Source files
------------

// File: rtl/vga_framebuffer_if.sv
// ============================================================================
// vga_framebuffer_if: renderer write/swap channel into the framebuffer
// Rev 1.0
// ============================================================================
`default_nettype none

interface vga_framebuffer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              swap_req;
  logic [DATA_W-1:0] clear_color;

  modport master (
    output wr_valid, wr_addr, wr_data, swap_req, clear_color,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, swap_req, clear_color,
    output wr_ready
  );
endinterface

`default_nettype wire

// File: rtl/vga_framebuffer.sv
// ============================================================================
// vga_framebuffer: double-buffered indexed framebuffer, vblank swap + clear
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_framebuffer #(
  parameter int H_RES         = 800,
  parameter int V_RES         = 480,
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 4,
  parameter int CLEAR_ON_SWAP = 1
) (
  input  wire logic              pixel_clk,
  input  wire logic              rst_n,
  input  wire logic [ADDR_W-1:0] rd_addr,
  output      logic [DATA_W-1:0] rd_data,
  input  wire logic              vblank,
  vga_framebuffer_if.slave       wr,
  output      logic              front_sel,
  output      logic              busy
);

  localparam int                N      = H_RES * V_RES;
  localparam int                IDX_W  = $clog2(N);
  localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    S_DRAW    = 2'd0,
    S_PENDING = 2'd1,
    S_CLEAR   = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_color;

  logic [DATA_W-1:0] buf0 [N];
  logic [DATA_W-1:0] buf1 [N];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [IDX_W-1:0]  rd_idx;

  assign rd_idx = rd_addr[IDX_W-1:0];

  // Out-of-range renderer writes complete the handshake but never reach the RAM.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr.wr_addr[IDX_W-1:0];
    mem_wdata = wr.wr_data;
    if (rst_n) begin
      if (state == S_DRAW) begin
        mem_we = wr.wr_valid && wr.wr_ready && (wr.wr_addr < N_A);
      end else if (state == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr[IDX_W-1:0];
        mem_wdata = clr_color;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (mem_we && front_sel) buf0[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge pixel_clk) begin
    if (mem_we && !front_sel) buf1[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_addr < N_A) begin
      rd_data <= front_sel ? buf1[rd_idx] : buf0[rd_idx];
    end else begin
      rd_data <= '0;
    end
  end

  // wr_ready/busy are assigned alongside each state change so they track the next state.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state       <= S_DRAW;
      front_sel   <= 1'b0;
      wr.wr_ready <= 1'b0;
      busy        <= 1'b0;
      clr_addr    <= '0;
      clr_color   <= '0;
    end else begin
      case (state)
        S_DRAW: begin
          wr.wr_ready <= 1'b1;
          busy        <= 1'b0;
          if (wr.swap_req) begin
            clr_color   <= wr.clear_color;
            state       <= S_PENDING;
            wr.wr_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_PENDING: begin
          if (vblank) begin
            front_sel <= ~front_sel;
            clr_addr  <= '0;
            if (CLEAR_ON_SWAP != 0) begin
              state <= S_CLEAR;
            end else begin
              state       <= S_DRAW;
              wr.wr_ready <= 1'b1;
              busy        <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          if (clr_addr == LAST_A) begin
            state       <= S_DRAW;
            wr.wr_ready <= 1'b1;
            busy        <= 1'b0;
            clr_addr    <= '0;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        default: begin
          state       <= S_DRAW;
          wr.wr_ready <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_framebuffer.sv
// ============================================================================
// tb_vga_framebuffer: directed checks on a 16x8 framebuffer (N = 128)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_framebuffer;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int AW = 8;
  localparam int DW = 4;
  localparam int N  = H * V;

  logic          pixel_clk = 1'b0;
  logic          rst_n     = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          vblank;
  logic          front_sel;
  logic          busy;

  always #5 pixel_clk = ~pixel_clk;

  vga_framebuffer_if #(.ADDR_W(AW), .DATA_W(DW)) wr ();

  vga_framebuffer #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_SWAP(1)
  ) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .vblank    (vblank),
    .wr        (wr),
    .front_sel (front_sel),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!wr.wr_ready && cycles < 1000) begin
      step();
      cycles++;
    end
    if (!wr.wr_ready) check("ready_timeout", wr.wr_ready, 1);
  endtask

  task automatic check_front(input string tag, input logic [DW-1:0] v);
    for (int a = 0; a < N; a++) begin
      rd_addr = AW'(a);
      step();
      check(tag, rd_data, v);
    end
  endtask

  task automatic do_swap(input logic [DW-1:0] color);
    wr.clear_color = color;
    wr.swap_req    = 1'b1;
    step();
    wr.swap_req    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rd_addr        = '0;
    vblank         = 1'b0;
    wr.wr_valid    = 1'b1;
    wr.wr_addr     = '0;
    wr.wr_data     = 4'hF;
    wr.swap_req    = 1'b1;
    wr.clear_color = 4'h0;

    // Reset held with traffic present
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_rd_data", rd_data, 0);
    check("rst_front", front_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", wr.wr_ready, 0);
    rst_n       = 1'b1;
    wr.wr_valid = 1'b0;
    wr.swap_req = 1'b0;
    step();
    check("rel_ready", wr.wr_ready, 1);
    check("rel_busy", busy, 0);

    // Bring both buffers to a known zero state
    vblank = 1'b1;
    do_swap(4'h0);
    wait_ready(cyc);
    do_swap(4'h0);
    wait_ready(cyc);
    check("init_front", front_sel, 0);

    // Write then immediate swap (vblank already high)
    wr.wr_valid = 1'b1;
    wr.wr_addr  = 8'd5;
    wr.wr_data  = 4'hA;
    rd_addr     = 8'd5;
    step();
    wr.wr_valid = 1'b0;
    do_swap(4'h0);
    check("ws_busy_t1", busy, 1);
    check("ws_ready_t1", wr.wr_ready, 0);
    check("ws_front_t1", front_sel, 0);
    step();
    check("ws_front_t2", front_sel, 1);
    check("ws_rd_old", rd_data, 0);
    step();
    check("ws_rd_new", rd_data, 4'hA);
    wait_ready(cyc);
    check("ws_clear_len", cyc, N - 1);

    // Deferred swap: vblank rises at T+10; an extra swap_req during CLEAR is ignored
    vblank = 1'b0;
    do_swap(4'h3);
    check("df_busy", busy, 1);
    check("df_ready", wr.wr_ready, 0);
    repeat (9) step();
    check("df_front_hold", front_sel, 1);
    vblank = 1'b1;
    step();
    check("df_front", front_sel, 0);
    check("df_busy_clear", busy, 1);
    cyc = 0;
    while (!wr.wr_ready && cyc < 1000) begin
      wr.swap_req = (cyc == 5);
      step();
      cyc++;
    end
    wr.swap_req = 1'b0;
    check("df_clear_len", cyc, N);
    repeat (4) step();
    check("ig_front", front_sel, 0);
    check("ig_busy", busy, 0);

    // New back buffer (buf1) holds the fill everywhere, including addr 5
    do_swap(4'h6);
    step();
    check_front("fill3", 4'h3);
    wait_ready(cyc);

    // Out-of-range read and write
    rd_addr = 8'd128;
    step();
    check("oor_rd_128", rd_data, 0);
    rd_addr = 8'd255;
    step();
    check("oor_rd_255", rd_data, 0);
    rd_addr = 8'd127;
    step();
    check("inr_rd_127", rd_data, 4'h3);
    wr.wr_valid = 1'b1;
    wr.wr_addr  = 8'd128;
    wr.wr_data  = 4'hF;
    check("oor_wr_ready", wr.wr_ready, 1);
    step();
    wr.wr_valid = 1'b0;
    check("oor_wr_ready_after", wr.wr_ready, 1);
    do_swap(4'h9);
    step();
    check_front("oor_keep6", 4'h6);
    wait_ready(cyc);

    // Reset in the middle of a clear of buf0
    do_swap(4'h2);
    step();
    repeat (50) step();
    check("mc_busy_pre", busy, 1);
    rst_n       = 1'b0;
    wr.wr_valid = 1'b1;
    wr.wr_addr  = 8'd3;
    wr.wr_data  = 4'hF;
    wr.swap_req = 1'b1;
    repeat (3) step();
    check("mc_rst_front", front_sel, 0);
    check("mc_rst_busy", busy, 0);
    check("mc_rst_ready", wr.wr_ready, 0);
    rst_n       = 1'b1;
    wr.wr_valid = 1'b0;
    wr.swap_req = 1'b0;
    step();
    check("mc_ready", wr.wr_ready, 1);
    check("mc_busy", busy, 0);
    check("mc_front", front_sel, 0);
    rd_addr = 8'd3;
    step();
    check("mc_cleared_3", rd_data, 4'h2);
    rd_addr = 8'd100;
    step();
    check("mc_untouched_100", rd_data, 4'h6);

    // The write presented during reset must not have landed in buf1
    do_swap(4'h0);
    step();
    rd_addr = 8'd3;
    step();
    check("rst_nowrite", rd_data, 4'h9);
    wait_ready(cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
